// File: rtl/cvxif_instr_pkg.sv
// cvxif_instr_pkg: shared CV-X-IF coprocessor constants
package cvxif_instr_pkg;
    localparam int unsigned CvxifResultDepth = 4;
endpackage

// File: rtl/cvxif_result_buffer_fifo.sv
// cvxif_result_buffer_fifo: in-order result storage with pointer and occupancy tracking
module cvxif_result_buffer_fifo #(
    parameter int unsigned Depth = 4,
    parameter type dtype = logic,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  dtype            data_i,
    output dtype            data_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic do_push, do_pop;
    dtype mem_q [Depth];

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CntW'(Depth);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    // a pop frees the slot in the same cycle, so a push at full is accepted when paired with a pop
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + PtrW'(do_push);
            rptr_q <= rptr_q + PtrW'(do_pop);
            cnt_q  <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/cvxif_result_buffer.sv
// cvxif_result_buffer: buffers single-cycle execution results for the CV-X-IF result handshake,
// with credit-based issue throttling and a sticky overflow flag
module cvxif_result_buffer
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned Depth = CvxifResultDepth,
    parameter int unsigned XLEN = 32,
    parameter type hartid_t = logic,
    parameter type id_t = logic
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_fire_i,
    output logic            issue_ready_o,
    input  logic            valid_i,
    input  logic [XLEN-1:0] result_i,
    input  hartid_t         hartid_i,
    input  id_t             id_i,
    input  logic [4:0]      rd_i,
    input  logic            we_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_data_o,
    output hartid_t         result_hartid_o,
    output id_t             result_id_o,
    output logic [4:0]      result_rd_o,
    output logic            result_we_o,
    output logic            overflow_o
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned SumW = CntW + 1;

    typedef struct packed {
        logic [XLEN-1:0] data;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t in_d, head, head_out;
    logic empty, full, pop;
    logic [CntW-1:0] count;
    logic inflight_q, overflow_q;

    assign in_d = {result_i, hartid_i, id_i, rd_i, we_i};

    cvxif_result_buffer_fifo #(
        .Depth(Depth),
        .dtype(entry_t)
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (valid_i),
        .pop_i  (pop),
        .data_i (in_d),
        .data_o (head),
        .empty_o(empty),
        .full_o (full),
        .count_o(count)
    );

    assign result_valid_o = !empty;
    assign pop            = result_valid_o && result_ready_i;
    // an issued instruction returns its result exactly one cycle later, so it holds a credit until then
    assign issue_ready_o  = ({1'b0, count} + SumW'(inflight_q)) < SumW'(Depth);
    assign overflow_o     = overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= issue_fire_i;
            overflow_q <= overflow_q | (valid_i & full & ~pop);
        end
    end

    assign head_out        = result_valid_o ? head : '0;
    assign result_data_o   = head_out.data;
    assign result_hartid_o = head_out.hartid;
    assign result_id_o     = head_out.id;
    assign result_rd_o     = head_out.rd;
    assign result_we_o     = head_out.we;
endmodule
